// File: rtl/letc_core_mtimer.sv
// letc_core_mtimer
// ----------------
// RISC-V machine timer for the LETC SoC. Holds the 64-bit mtime counter and
// the 64-bit mtimecmp compare register behind a one-outstanding valid/ready
// register port, and raises a level interrupt while mtime >= mtimecmp.
//
// Parameters:
//   PRESCALE           clk cycles per mtime increment (1..65535)
//
// Ports:
//   clk                core clock
//   rst_n              synchronous active-low reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_we             1 = write, 0 = read
//   req_addr           byte offset: 0x0 mtime lo, 0x4 mtime hi,
//                      0x8 mtimecmp lo, 0xC mtimecmp hi
//   req_wdata          32-bit write data
//   rsp_valid/ready    response handshake
//   rsp_rdata          read data (0 for writes and errors)
//   rsp_err            request address was not word aligned
//   timer_irq_pending  registered mtime >= mtimecmp (unsigned 64-bit)

module letc_core_mtimer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        timer_irq_pending
);

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  localparam logic [15:0] TickMax = 16'(PRESCALE - 1);

  state_e      state_q;
  logic        reqReady_q;
  logic        rspValid_q;
  logic [31:0] rspRdata_q;
  logic        rspErr_q;
  logic        irq_q;

  logic [15:0] tickCnt_q, tickCnt_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;

  logic        accept;
  logic        aligned;
  logic        wrEn;
  logic        tick;
  logic [31:0] readData;

  // A request is taken only while idle and out of reset; reqReady_q is held
  // low during reset so nothing can slip in before the first released edge.
  assign accept  = (state_q == IDLE) && reqReady_q && req_valid;
  assign aligned = (req_addr[1:0] == 2'b00);
  assign wrEn    = accept && req_we && aligned;

  // Next-state for the prescaler, mtime and mtimecmp, plus the read mux.
  // A register write overrides the increment for that cycle: the written
  // half takes the data and the other half simply holds, so no carry can
  // leak across. The prescaler keeps running regardless of writes.
  always_comb begin
    tick       = (tickCnt_q == TickMax);
    tickCnt_d  = tick ? 16'd0 : tickCnt_q + 16'd1;
    mtime_d    = mtime_q + {63'd0, tick};
    mtimecmp_d = mtimecmp_q;
    readData   = 32'd0;

    case (req_addr[3:2])
      2'd0:    readData = mtime_q[31:0];
      2'd1:    readData = mtime_q[63:32];
      2'd2:    readData = mtimecmp_q[31:0];
      default: readData = mtimecmp_q[63:32];
    endcase

    if (wrEn) begin
      case (req_addr[3:2])
        2'd0:    mtime_d = {mtime_q[63:32], req_wdata};
        2'd1:    mtime_d = {req_wdata, mtime_q[31:0]};
        2'd2:    mtimecmp_d = {mtimecmp_q[63:32], req_wdata};
        default: mtimecmp_d = {req_wdata, mtimecmp_q[31:0]};
      endcase
    end
  end

  // Timer state. The interrupt is compared against the next-state values so
  // a crossing or a clearing write shows up on the same edge as the update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tickCnt_q  <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      tickCnt_q  <= tickCnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_d >= mtimecmp_d);
    end
  end

  // Register-port FSM with registered handshake outputs. Read data is taken
  // from the current registers in the accept cycle, i.e. before that cycle's
  // increment. The response is held unchanged until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      reqReady_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspRdata_q <= 32'd0;
      rspErr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          reqReady_q <= 1'b1;
          if (accept) begin
            state_q    <= RESP;
            reqReady_q <= 1'b0;
            rspValid_q <= 1'b1;
            rspRdata_q <= (req_we || !aligned) ? 32'd0 : readData;
            rspErr_q   <= !aligned;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q    <= IDLE;
            reqReady_q <= 1'b1;
            rspValid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b0;
          rspValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready         = reqReady_q;
  assign rsp_valid         = rspValid_q;
  assign rsp_rdata         = rspRdata_q;
  assign rsp_err           = rspErr_q;
  assign timer_irq_pending = irq_q;

endmodule

// File: tb/tb_letc_core_mtimer.sv
// Testbench for letc_core_mtimer. Two instances (PRESCALE=1 and PRESCALE=4)
// share every input; each has its own outputs. A small behavioural model of
// mtime/mtimecmp/prescaler per instance tracks the expected interrupt level
// on every cycle, and directed vectors plus hand sequences check the port.

module tb_letc_core_mtimer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        reqReady1, rspValid1, rspErr1, irq1;
  logic [31:0] rspRdata1;
  logic        reqReady4, rspValid4, rspErr4, irq4;
  logic [31:0] rspRdata4;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4
  logic [63:0] mMt[2];
  logic [63:0] mCmp[2];
  int unsigned mTc[2];
  int unsigned mPre[2] = '{1, 4};
  logic        pendWr;
  logic [1:0]  pendIdx;
  logic [31:0] pendData;

  // Results of the most recent transaction
  logic [31:0] rd[2];
  logic        er[2];
  logic [31:0] snap[2];

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  letc_core_mtimer #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(reqReady1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspValid1), .rsp_ready(rsp_ready),
    .rsp_rdata(rspRdata1), .rsp_err(rspErr1),
    .timer_irq_pending(irq1)
  );

  letc_core_mtimer #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(reqReady4), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspValid4), .rsp_ready(rsp_ready),
    .rsp_rdata(rspRdata4), .rsp_err(rspErr4),
    .timer_irq_pending(irq4)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input int d, input logic [3:0] a);
    case (a[3:2])
      2'd0:    return mMt[d][31:0];
      2'd1:    return mMt[d][63:32];
      2'd2:    return mCmp[d][31:0];
      default: return mCmp[d][63:32];
    endcase
  endfunction

  // One clock: advance the model at the rising edge, then at the falling
  // edge compare both interrupt outputs with the model level.
  task automatic tick();
    logic isTick;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mMt[d]  = 64'd0;
        mCmp[d] = '1;
        mTc[d]  = 0;
      end else begin
        isTick = (mTc[d] == mPre[d] - 1);
        mTc[d] = isTick ? 0 : mTc[d] + 1;
        if (pendWr && pendIdx == 2'd0)      mMt[d][31:0]   = pendData;
        else if (pendWr && pendIdx == 2'd1) mMt[d][63:32]  = pendData;
        else if (isTick)                    mMt[d]         = mMt[d] + 64'd1;
        if (pendWr && pendIdx == 2'd2)      mCmp[d][31:0]  = pendData;
        if (pendWr && pendIdx == 2'd3)      mCmp[d][63:32] = pendData;
      end
    end
    pendWr = 1'b0;
    @(negedge clk);
    checkOutput("irq_p1", irq1, rst_n && (mMt[0] >= mCmp[0]));
    checkOutput("irq_p4", irq4, rst_n && (mMt[1] >= mCmp[1]));
  endtask

  // Full transaction with rsp_ready held high: accept edge, then the edge
  // that consumes the response. Leaves the bench at a falling edge with
  // both instances idle again.
  task automatic doReq(input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata);
    int waitCnt = 0;
    while (!(reqReady1 && reqReady4) && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    if (waitCnt == 20) checkOutput("req_ready_timeout", 0, 1);
    snap[0]   = modelRead(0, addr);
    snap[1]   = modelRead(1, addr);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    if (we && addr[1:0] == 2'b00) begin
      pendWr   = 1'b1;
      pendIdx  = addr[3:2];
      pendData = wdata;
    end
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    checkOutput("rsp_valid_p1", rspValid1, 1);
    checkOutput("rsp_valid_p4", rspValid4, 1);
    rd[0] = rspRdata1;
    rd[1] = rspRdata4;
    er[0] = rspErr1;
    er[1] = rspErr4;
    tick();
  endtask

  // Read that is checked against the model on both instances
  task automatic readModel(input logic [3:0] addr, input string name);
    doReq(1'b0, addr, 32'd0);
    checkOutput({name, "_p1"}, rd[0], snap[0]);
    checkOutput({name, "_p4"}, rd[1], snap[1]);
  endtask

  // Drive one table vector and compare both instances' responses
  task automatic applyStimulus(input int i);
    doReq(vecs[i].we, vecs[i].addr, vecs[i].wdata);
    checkOutput($sformatf("vec%0d_rdata_p1", i), rd[0], vecs[i].expRdata);
    checkOutput($sformatf("vec%0d_rdata_p4", i), rd[1], vecs[i].expRdata);
    checkOutput($sformatf("vec%0d_err_p1", i), er[0], vecs[i].expErr);
    checkOutput($sformatf("vec%0d_err_p4", i), er[1], vecs[i].expErr);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;

    // Compare-register and misaligned accesses; expectations are the same
    // on both instances since they do not depend on mtime.
    vecs[0]  = '{1'b0, 4'h8, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{1'b0, 4'hC, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b1, 4'hC, 32'h1234_5678, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 4'h8, 32'h9ABC_DEF0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 4'h8, 32'h0,         32'h9ABC_DEF0, 1'b0};
    vecs[5]  = '{1'b0, 4'hC, 32'h0,         32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b0, 4'h2, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{1'b1, 4'h9, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 4'h1, 32'hDEAD_BEEF, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 4'h8, 32'h0,         32'h9ABC_DEF0, 1'b0};
    vecs[10] = '{1'b1, 4'hE, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b0, 4'hC, 32'h0,         32'h1234_5678, 1'b0};
    vecs[12] = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[13] = '{1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 4'h8, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[15] = '{1'b0, 4'h3, 32'h0,         32'h0,         1'b1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 4'h0;
    req_wdata = 32'd0;
    rsp_ready = 1'b1;
    pendWr    = 1'b0;
    pendIdx   = 2'd0;
    pendData  = 32'd0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_req_ready_p1", reqReady1, 0);
    checkOutput("rst_req_ready_p4", reqReady4, 0);
    checkOutput("rst_rsp_valid_p1", rspValid1, 0);
    checkOutput("rst_rsp_rdata_p1", rspRdata1, 0);
    checkOutput("rst_rsp_err_p1", rspErr1, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_release_p1", reqReady1, 1);
    checkOutput("ready_after_release_p4", reqReady4, 1);

    // Back-to-back mtime reads right after release: k-th read is accepted
    // at released edge 2k+2 and sees the count before it. PRESCALE=1 has
    // counted 2k+1 edges; PRESCALE=4 steps on edges 4, 8, 12, ...
    for (int k = 0; k < 6; k++) begin
      doReq(1'b0, 4'h0, 32'd0);
      checkOutput($sformatf("prescale1_read%0d", k), rd[0], 32'(2 * k + 1));
      checkOutput($sformatf("prescale4_read%0d", k), rd[1], 32'((2 * k + 1) / 4));
    end

    // Idle stretch, then mtime against the model
    repeat (10) tick();
    readModel(4'h0, "idle_mtime_lo");

    // Table vectors
    for (int i = 0; i < 16; i++) applyStimulus(i);
    readModel(4'h0, "mtime_after_misaligned");
    readModel(4'h4, "mtime_hi_after_misaligned");

    // Low-to-high carry
    doReq(1'b1, 4'h4, 32'h0000_0000);
    doReq(1'b1, 4'h0, 32'hFFFF_FFFE);
    doReq(1'b0, 4'h4, 32'd0);
    checkOutput("carry_hi_before_wrap", rd[0], 32'h0);
    doReq(1'b0, 4'h0, 32'd0);
    checkOutput("carry_lo_after_wrap", rd[0], 32'h1);
    doReq(1'b0, 4'h4, 32'd0);
    checkOutput("carry_hi_after_wrap", rd[0], 32'h1);

    // All ones wraps to zero
    doReq(1'b1, 4'h4, 32'hFFFF_FFFF);
    doReq(1'b1, 4'h0, 32'hFFFF_FFFF);
    doReq(1'b0, 4'h4, 32'd0);
    checkOutput("wrap64_hi", rd[0], 32'h0);
    doReq(1'b0, 4'h0, 32'd0);
    checkOutput("wrap64_lo", rd[0], 32'h2);

    // Write wins over the increment in the same cycle
    doReq(1'b1, 4'h0, 32'h0000_1000);
    doReq(1'b0, 4'h0, 32'd0);
    checkOutput("write_no_plus1", rd[0], 32'h0000_1001);

    // Write of all ones to the low half must not carry on the write edge;
    // compare sits at 6_00000000 so the per-cycle IRQ check sees a carry.
    doReq(1'b1, 4'hC, 32'h0000_0006);
    doReq(1'b1, 4'h8, 32'h0000_0000);
    doReq(1'b1, 4'h4, 32'h0000_0005);
    doReq(1'b1, 4'h0, 32'hFFFF_FFFF);
    checkOutput("irq_after_carry_p1", irq1, 1);
    doReq(1'b0, 4'h4, 32'd0);
    checkOutput("hi_after_carry", rd[0], 32'h6);

    // Compare crossing at 0x100, then a clearing write
    doReq(1'b1, 4'h8, 32'hFFFF_FFFF);
    doReq(1'b1, 4'hC, 32'hFFFF_FFFF);
    doReq(1'b1, 4'h4, 32'h0);
    doReq(1'b1, 4'h0, 32'h0);
    doReq(1'b1, 4'hC, 32'h0);
    doReq(1'b1, 4'h8, 32'h0000_0100);
    w = 0;
    while (mMt[0] < 64'h100 && w < 400) begin
      tick();
      w++;
    end
    checkOutput("irq_at_0x100_p1", irq1, 1);
    doReq(1'b0, 4'h0, 32'd0);
    checkOutput("mtime_at_crossing", rd[0], 32'h100);
    doReq(1'b1, 4'h8, 32'hFFFF_FFFF);
    checkOutput("irq_cleared_p1", irq1, 0);

    // Response held for 5 cycles with rsp_ready low
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'h8;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold%0d_rsp_valid", i), rspValid1, 1);
      checkOutput($sformatf("hold%0d_rdata", i), rspRdata1, 32'hFFFF_FFFF);
      checkOutput($sformatf("hold%0d_err", i), rspErr1, 0);
      checkOutput($sformatf("hold%0d_req_ready", i), reqReady1, 0);
      checkOutput($sformatf("hold%0d_req_ready_p4", i), reqReady4, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("hold_released_rsp_valid", rspValid1, 0);
    checkOutput("hold_released_req_ready", reqReady1, 1);

    // Reset while a response is pending
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 4'hC;
    tick();
    req_valid = 1'b0;
    checkOutput("pre_reset_rsp_valid", rspValid1, 1);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_reset_rsp_valid_p1", rspValid1, 0);
    checkOutput("mid_reset_rsp_valid_p4", rspValid4, 0);
    checkOutput("mid_reset_req_ready", reqReady1, 0);
    checkOutput("mid_reset_rdata", rspRdata1, 0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    doReq(1'b0, 4'h0, 32'd0);
    checkOutput("post_reset_mtime_p1", rd[0], 32'h1);
    checkOutput("post_reset_mtime_p4", rd[1], 32'h0);
    readModel(4'h8, "post_reset_cmp_lo");
    readModel(4'hC, "post_reset_cmp_hi");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
